// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state encodings, default widths and requester IDs for mem_arbiter
package mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_BITS = 5;
  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;
endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick: two-way winner selection; pointer names the requester favoured on a tie
import mem_arbiter_pkg::*;
module arb_pick (
  input  logic req0,
  input  logic req1,
  input  logic pointer,
  output logic winner
);
  // a lone requester always wins; a tie goes to the pointer
  always_comb winner = (req0 && req1) ? pointer : (req1 ? ID_REQ1 : ID_REQ0);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester single-port memory arbiter; define MEM_ARB_ROUND_ROBIN_EN for round-robin, else fixed priority to requester 0
import mem_arbiter_pkg::*;
module mem_arbiter #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_BITS = DEF_ADDR_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  w_r0,
  input  logic                  w_r1,
  input  logic [ADDR_BITS-1:0]  addr0,
  input  logic [ADDR_BITS-1:0]  addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  done0,
  output logic                  done1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_en,
  output logic                  mem_w_r,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  state_t state;
  logic owner;
  logic ptr;
  logic winner;
  arb_pick u_pick (.req0(req0), .req1(req1), .pointer(ptr), .winner(winner));
`ifdef MEM_ARB_ROUND_ROBIN_EN
  // after each grant the other requester gets the tie-break
  always_ff @(posedge clk)
    if (rst) ptr <= ID_REQ0;
    else if (state == IDLE && (req0 || req1)) ptr <= ~winner;
`else
  assign ptr = ID_REQ0;
`endif
  // transaction FSM; the memory drive registers double as the latched request
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= ID_REQ0;
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      rdata <= '0;
      mem_en <= 1'b0;
      mem_w_r <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: if (req0 || req1) begin
          state <= ACCESS;
          owner <= winner;
          gnt0 <= winner == ID_REQ0;
          gnt1 <= winner == ID_REQ1;
          mem_en <= 1'b1;
          mem_w_r <= winner ? w_r1 : w_r0;
          mem_addr <= winner ? addr1 : addr0;
          mem_wdata <= winner ? wdata1 : wdata0;
        end
        ACCESS: begin
          mem_en <= 1'b0;
          state <= mem_w_r ? IDLE : RESP;
          done0 <= mem_w_r && owner == ID_REQ0;
          done1 <= mem_w_r && owner == ID_REQ1;
        end
        RESP: begin
          state <= IDLE;
          rdata <= mem_rdata;
          done0 <= owner == ID_REQ0;
          done1 <= owner == ID_REQ1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
